alu_mul_seq: RTL and testbench

- Multi-cycle multiply sequencer that borrows the shared 16-bit ALU and runs a shift-add product, one ALU add per cycle.
- Sits beside the execute stage. While busy it asserts alu_own, and the execute-stage operand mux hands the ALU control inputs to this block.
- Accepts one request via valid/ready, returns a 2*WIDTH product via valid/ready.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/mul_seq_fsm.sv | 94 +++++++++
 rtl/alu_mul_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU package: opcode constants used by every block that drives the
// shared 16-bit ALU, plus the state encoding of the multiply sequencer.
package alu_pkg;

   // ALU operation select codes
   localparam logic [3:0] OP_ROL = 4'b0000;
   localparam logic [3:0] OP_SLL = 4'b0001;
   localparam logic [3:0] OP_SRA = 4'b0010;
   localparam logic [3:0] OP_SRL = 4'b0011;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;

   // Multiply sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CALC   = 3'd1,
      NEG_LO = 3'd2,
      NEG_HI = 3'd3,
      DONE   = 3'd4
   } mul_state_e;

   // True in the states where the sequencer drives the shared ALU
   function automatic logic owns_alu(input mul_state_e st);
      logic own_v;
      case (st)
         CALC, NEG_LO, NEG_HI: own_v = 1'b1;
         default:              own_v = 1'b0;
      endcase
      return own_v;
   endfunction

endpackage

// File: rtl/mul_seq_fsm.sv
// Control FSM of the multiply sequencer: state register, iteration counter
// and next-state logic. The optional negate states exist only when
// MUL_SIGNED_EN is defined.
module mul_seq_fsm
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic       rsp_ready,
`ifdef MUL_SIGNED_EN
   input  logic       neg_flag,
`endif
   output mul_state_e state,
   output logic       accept,
   output logic       done_entry,
   output logic       own_next
);

   mul_state_e       state_r;
   mul_state_e       state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic             accept_s;

   // Next-state decode; a request is only taken while idle
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               state_nx_s = CALC;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == CNT_W'(1)) begin
`ifdef MUL_SIGNED_EN
               state_nx_s = neg_flag ? NEG_LO : DONE;
`else
               state_nx_s = DONE;
`endif
            end else begin
               state_nx_s = CALC;
            end
         end
`ifdef MUL_SIGNED_EN
         NEG_LO: state_nx_s = NEG_HI;
         NEG_HI: state_nx_s = DONE;
`endif
         DONE: begin
            if (rsp_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Iteration counter: loaded with WIDTH at accept, one step per CALC cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (accept_s) begin
         cnt_r <= CNT_W'(WIDTH);
      end else if (state_r == CALC) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign state      = state_r;
   assign accept     = accept_s;
   assign done_entry = (state_nx_s == DONE) && (state_r != DONE);
   assign own_next   = owns_alu(state_nx_s);

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-add multiplier that borrows the shared ALU, one add per
// cycle, with valid/ready request and response handshakes.
// Optional feature macro: MUL_SIGNED_EN (adds req_signed and the two-cycle
// result negation through the ALU).
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
`ifdef MUL_SIGNED_EN
   input  logic             req_signed,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_hi,
   output logic [WIDTH-1:0] rsp_lo,
   output logic             alu_own,
   output logic [WIDTH-1:0] alu_InA,
   output logic [WIDTH-1:0] alu_InB,
   output logic             alu_Cin,
   output logic [3:0]       alu_Oper,
   output logic             alu_invA,
   output logic             alu_invB,
   output logic             alu_sign,
   input  logic [WIDTH-1:0] alu_Out,
   input  logic             alu_CF
);

   mul_state_e       state_s;
   logic             accept_s;
   logic             done_entry_s;
   logic             own_next_s;

   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] mplr_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] acc_d_s;
   logic [WIDTH-1:0] mplr_d_s;
   logic [WIDTH-1:0] a_load_s;
   logic [WIDTH-1:0] b_load_s;
   logic [2*WIDTH-1:0] shift_s;

   logic             rsp_valid_r;
   logic [WIDTH-1:0] rsp_hi_r;
   logic [WIDTH-1:0] rsp_lo_r;
   logic             alu_own_r;

`ifdef MUL_SIGNED_EN
   logic             neg_flag_r;
   logic             borrow_r;
`endif

   mul_seq_fsm #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .rsp_ready  (rsp_ready),
`ifdef MUL_SIGNED_EN
      .neg_flag   (neg_flag_r),
`endif
      .state      (state_s),
      .accept     (accept_s),
      .done_entry (done_entry_s),
      .own_next   (own_next_s)
   );

`ifdef MUL_SIGNED_EN
   // Signed requests load operand magnitudes; 0x8000 maps onto itself,
   // which is the correct unsigned magnitude
   always_comb begin
      a_load_s = (req_signed && req_a[WIDTH-1]) ? (~req_a + WIDTH'(1)) : req_a;
      b_load_s = (req_signed && req_b[WIDTH-1]) ? (~req_b + WIDTH'(1)) : req_b;
   end
`else
   // Unsigned only: operands load unchanged
   always_comb begin
      a_load_s = req_a;
      b_load_s = req_b;
   end
`endif

   // One shift-add step: carry, sum and multiplier shifted right as one word
   assign shift_s = {alu_CF, alu_Out, mplr_r[WIDTH-1:1]};

   // Next values of the accumulator and multiplier registers
   always_comb begin
      acc_d_s  = acc_r;
      mplr_d_s = mplr_r;
      case (state_s)
         IDLE: begin
            acc_d_s  = accept_s ? '0 : acc_r;
            mplr_d_s = accept_s ? b_load_s : mplr_r;
         end
         CALC: begin
            acc_d_s  = shift_s[2*WIDTH-1:WIDTH];
            mplr_d_s = shift_s[WIDTH-1:0];
         end
`ifdef MUL_SIGNED_EN
         NEG_LO: mplr_d_s = alu_Out;
         NEG_HI: acc_d_s  = alu_Out;
`endif
         default: begin
            acc_d_s  = acc_r;
            mplr_d_s = mplr_r;
         end
      endcase
   end

   // ALU drive mux; everything is zero whenever the ALU is not owned
   always_comb begin
      alu_InA  = '0;
      alu_InB  = '0;
      alu_Cin  = 1'b0;
      alu_Oper = 4'b0000;
      alu_invA = 1'b0;
      alu_invB = 1'b0;
      case (state_s)
         CALC: begin
            alu_InA  = acc_r;
            alu_InB  = mplr_r[0] ? mcand_r : '0;
            alu_Oper = OP_ADD;
         end
`ifdef MUL_SIGNED_EN
         NEG_LO: begin
            alu_InA  = mplr_r;
            alu_invA = 1'b1;
            alu_Cin  = 1'b1;
            alu_Oper = OP_ADD;
         end
         NEG_HI: begin
            alu_InA  = acc_r;
            alu_invA = 1'b1;
            alu_Cin  = borrow_r;
            alu_Oper = OP_ADD;
         end
`endif
         default: begin
            alu_InA  = '0;
            alu_InB  = '0;
            alu_Cin  = 1'b0;
            alu_Oper = 4'b0000;
         end
      endcase
   end

   // Datapath registers: accumulator, multiplier, multiplicand
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r   <= '0;
         mplr_r  <= '0;
         mcand_r <= '0;
      end else begin
         acc_r   <= acc_d_s;
         mplr_r  <= mplr_d_s;
         mcand_r <= accept_s ? a_load_s : mcand_r;
      end
   end

`ifdef MUL_SIGNED_EN
   // Sign of the result captured at accept; borrow carried from NEG_LO to NEG_HI
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_flag_r <= 1'b0;
         borrow_r   <= 1'b0;
      end else begin
         neg_flag_r <= accept_s ? (req_signed & (req_a[WIDTH-1] ^ req_b[WIDTH-1])) : neg_flag_r;
         borrow_r   <= (state_s == NEG_LO) ? alu_CF : borrow_r;
      end
   end
`endif

   // Response registers: loaded with the final product on entry to DONE and
   // held until the consumer takes it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_r <= 1'b0;
         rsp_hi_r    <= '0;
         rsp_lo_r    <= '0;
      end else if (done_entry_s) begin
         rsp_valid_r <= 1'b1;
         rsp_hi_r    <= acc_d_s;
         rsp_lo_r    <= mplr_d_s;
      end else if (rsp_valid_r && rsp_ready) begin
         rsp_valid_r <= 1'b0;
         rsp_hi_r    <= rsp_hi_r;
         rsp_lo_r    <= rsp_lo_r;
      end else begin
         rsp_valid_r <= rsp_valid_r;
         rsp_hi_r    <= rsp_hi_r;
         rsp_lo_r    <= rsp_lo_r;
      end
   end

   // ALU ownership flag, registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_own_r <= 1'b0;
      end else begin
         alu_own_r <= own_next_s;
      end
   end

   assign req_ready = (state_s == IDLE);
   assign rsp_valid = rsp_valid_r;
   assign rsp_hi    = rsp_hi_r;
   assign rsp_lo    = rsp_lo_r;
   assign alu_own   = alu_own_r;
   assign alu_sign  = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural model of the shared
// ALU; expected products go through a scoreboard queue.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
`ifdef MUL_SIGNED_EN
   logic        req_signed;
`endif
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_hi;
   logic [15:0] rsp_lo;
   logic        alu_own;
   logic [15:0] alu_InA;
   logic [15:0] alu_InB;
   logic        alu_Cin;
   logic [3:0]  alu_Oper;
   logic        alu_invA;
   logic        alu_invB;
   logic        alu_sign;
   logic [15:0] alu_Out;
   logic        alu_CF;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] sb_q[$];

   alu_mul_seq dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
`ifdef MUL_SIGNED_EN
      .req_signed (req_signed),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_hi     (rsp_hi),
      .rsp_lo     (rsp_lo),
      .alu_own    (alu_own),
      .alu_InA    (alu_InA),
      .alu_InB    (alu_InB),
      .alu_Cin    (alu_Cin),
      .alu_Oper   (alu_Oper),
      .alu_invA   (alu_invA),
      .alu_invB   (alu_invB),
      .alu_sign   (alu_sign),
      .alu_Out    (alu_Out),
      .alu_CF     (alu_CF)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: only the add path is needed by this block
   always_comb begin
      logic [15:0] opa;
      logic [15:0] opb;
      logic [16:0] sum;
      opa = alu_invA ? ~alu_InA : alu_InA;
      opb = alu_invB ? ~alu_InB : alu_InB;
      sum = {1'b0, opa} + {1'b0, opb} + {16'b0, alu_Cin};
      if (alu_Oper == 4'b0100) begin
         alu_Out = sum[15:0];
         alu_CF  = sum[16];
      end else begin
         alu_Out = 16'h0000;
         alu_CF  = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request and follow it to its response (or to an abort by reset)
   task automatic run_req(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                          input int bp, input int exp_lat, input logic spur, input int abort_at);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0]        exp_p;
      int                 lat;
      int                 own_cnt;
      logic               seen;
      for (int w = 0; w < 50 && !req_ready; w++) @(negedge clk);
      if (!req_ready) check("req_ready_wait", {63'b0, req_ready}, 64'd1);
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      exp_p = sgn ? 32'(sa * sb) : ({16'b0, a} * {16'b0, b});
      req_a = a;
      req_b = b;
`ifdef MUL_SIGNED_EN
      req_signed = sgn;
`endif
      rsp_ready = (bp == 0);
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      if (abort_at == 0) sb_q.push_back(exp_p);
      own_cnt = 0;
      seen = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (spur && k == 4) begin
            req_valid = 1'b1;
            req_a = 16'h5555;
            req_b = 16'h0003;
         end
         if (spur && k >= 4 && k <= 8) check("ignored_req_ready", {63'b0, req_ready}, 64'd0);
         if (spur && k == 9) req_valid = 1'b0;
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_req_ready", {63'b0, req_ready}, 64'd1);
            check("abort_rsp_valid", {63'b0, rsp_valid}, 64'd0);
            check("abort_alu_own", {63'b0, alu_own}, 64'd0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (rsp_valid) begin
            seen = 1'b1;
            lat = k;
            break;
         end
         if (alu_own) own_cnt++;
         @(negedge clk);
      end
      if (!seen) begin
         check("rsp_timeout", {63'b0, seen}, 64'd1);
         return;
      end
      check("rsp_latency", 64'(lat), 64'(exp_lat));
      check("alu_own_cycles", 64'(own_cnt), 64'(exp_lat - 1));
      for (int i = 0; i < bp; i++) begin
         check("bp_rsp_valid", {63'b0, rsp_valid}, 64'd1);
         check("bp_hold", {32'b0, rsp_hi, rsp_lo}, {32'b0, sb_q[0]});
         check("bp_req_ready", {63'b0, req_ready}, 64'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      check("alu_idle_drive",
            {24'b0, alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign}, 64'd0);
      if (sb_q.size() > 0) check("product", {32'b0, rsp_hi, rsp_lo}, {32'b0, sb_q.pop_front()});
      else check("sb_underflow", 64'(sb_q.size()), 64'd1);
      @(negedge clk);
      check("post_hs_req_ready", {63'b0, req_ready}, 64'd1);
      check("post_hs_rsp_valid", {63'b0, rsp_valid}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_a = 16'h0000;
      req_b = 16'h0000;
`ifdef MUL_SIGNED_EN
      req_signed = 1'b0;
`endif
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready", {63'b0, req_ready}, 64'd1);
      check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      check("rst_alu_own", {63'b0, alu_own}, 64'd0);
      check("rst_rsp_data", {32'b0, rsp_hi, rsp_lo}, 64'd0);
      check("rst_alu_drive",
            {24'b0, alu_InA, alu_InB, alu_Cin, alu_Oper, alu_invA, alu_invB, alu_sign}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      run_req(16'h0003, 16'h0005, 1'b0, 0, 17, 1'b0, 0);
      run_req(16'hFFFF, 16'hFFFF, 1'b0, 0, 17, 1'b0, 0);
      run_req(16'h1234, 16'h0010, 1'b0, 5, 17, 1'b1, 0);
      run_req(16'h1111, 16'h0002, 1'b0, 0, 17, 1'b0, 8);
      run_req(16'h0007, 16'h0009, 1'b0, 0, 17, 1'b0, 0);
      run_req(16'h0000, 16'hABCD, 1'b0, 0, 17, 1'b0, 0);
      run_req(16'h00FF, 16'h0101, 1'b0, 0, 17, 1'b0, 0);
      run_req(16'h8000, 16'h0002, 1'b0, 2, 17, 1'b0, 0);
`ifdef MUL_SIGNED_EN
      run_req(16'hFFFD, 16'h0005, 1'b1, 0, 19, 1'b0, 0);
      run_req(16'h8000, 16'hFFFF, 1'b1, 0, 17, 1'b0, 0);
      run_req(16'h0007, 16'hFFFE, 1'b1, 0, 19, 1'b0, 0);
`endif
      check("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
